clk_freq_monitor: RTL and testbench

Synchronous frequency and lock verifier that sits directly downstream of the PLL simulation model. It consumes the PLL's `LOCKED` flag and one generated output clock, sampled in the system clock domain. It counts output-clock rising edges over a fixed gate window, checks the count against an expected value with a tolerance, and asserts `verified` only after a run of consecutive passing windows. Loss of lock or an out-of-range window raises `fault`.

---
 rtl/clkmon_pkg.sv | 18 +
 rtl/sync_edge_detect.sv | 32 +++
 rtl/clk_freq_monitor.sv | 140 ++++++++++++++
 tb/tb_clk_freq_monitor.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkmon_pkg.sv
// clk_freq_monitor shared types and defaults.
// FSM encoding, default window/tolerance constants, pass-counter width.
package clkmon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOCK,
    MEASURE,
    EVAL
  } state_e;

  localparam int WINDOW_DEF    = 1024;
  localparam int EXPECTED_DEF  = 256;
  localparam int TOLERANCE_DEF = 4;
  localparam int PASSES_DEF    = 4;
  localparam int PASS_W        = 4;

endpackage

// File: rtl/sync_edge_detect.sv
// 2-FF synchronizer with optional rising-edge pulse output.
// EDGE=1: one-cycle pulse per rising edge; EDGE=0: synced level.
module sync_edge_detect #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], d};
  end

  generate
    if (EDGE) begin : g_edge
      logic prev;
      always_ff @(posedge clk) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= sync[1];
      end
      assign q = sync[1] & ~prev;
    end else begin : g_level
      assign q = sync[1];
    end
  endgenerate

endmodule

// File: rtl/clk_freq_monitor.sv
// PLL output frequency / lock verifier over a fixed gate window.
// CLKMON_STICKY_FAULT_EN: fault latches until RSTN.
module clk_freq_monitor
  import clkmon_pkg::*;
#(
  parameter int WINDOW    = WINDOW_DEF,
  parameter int EXPECTED  = EXPECTED_DEF,
  parameter int TOLERANCE = TOLERANCE_DEF,
  parameter int PASSES    = PASSES_DEF,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic             enable,
  input  logic             pll_locked,
  input  logic             mon_clk,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             verified,
  output logic             fault
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic signed [CNT_W:0] EXP_S = (CNT_W+1)'(EXPECTED);
  localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOLERANCE);
  localparam logic [PASS_W-1:0] PASS_MAX = PASS_W'(PASSES);

`ifdef CLKMON_STICKY_FAULT_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  state_e state, state_nx;

  logic              lock_s;
  logic              edge_p;
  logic [WIN_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [PASS_W-1:0] pass_cnt;
  logic [PASS_W-1:0] pass_inc;
  logic signed [CNT_W:0] diff;
  logic signed [CNT_W:0] mag;
  logic              in_tol;
  logic              lost;
  logic              enter_meas;

  sync_edge_detect #(.EDGE(1'b1)) u_mon (
    .clk   (clk),
    .rst_n (RSTN),
    .d     (mon_clk),
    .q     (edge_p)
  );

  sync_edge_detect #(.EDGE(1'b0)) u_lock (
    .clk   (clk),
    .rst_n (RSTN),
    .d     (pll_locked),
    .q     (lock_s)
  );

  always_ff @(posedge clk) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    lost     = 1'b0;
    unique case (state)
      IDLE:      if (enable) state_nx = WAIT_LOCK;
      WAIT_LOCK: if (lock_s) state_nx = MEASURE;
      MEASURE:   if (win_cnt == WIN_LAST) state_nx = EVAL;
      EVAL:      state_nx = MEASURE;
      default:   state_nx = IDLE;
    endcase
    // enable dominates lock loss: no fault when both drop together
    if (!enable) begin
      state_nx = IDLE;
    end else if (!lock_s && (state == MEASURE || state == EVAL)) begin
      state_nx = WAIT_LOCK;
      lost     = 1'b1;
    end
  end

  assign enter_meas = (state_nx == MEASURE) && (state != MEASURE);

  always_comb begin
    diff     = $signed({1'b0, edge_cnt}) - EXP_S;
    mag      = diff[CNT_W] ? -diff : diff;
    in_tol   = (mag <= TOL_S);
    pass_inc = (pass_cnt == PASS_MAX) ? PASS_MAX : pass_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      win_cnt     <= '0;
      edge_cnt    <= '0;
      pass_cnt    <= '0;
      count       <= '0;
      count_valid <= 1'b0;
      verified    <= 1'b0;
      fault       <= 1'b0;
    end else begin
      count_valid <= 1'b0;

      if (state == MEASURE) win_cnt <= win_cnt + 1'b1;
      else                  win_cnt <= '0;

      if (enter_meas)
        edge_cnt <= '0;
      else if (state == MEASURE && edge_p && edge_cnt != '1)
        edge_cnt <= edge_cnt + 1'b1;

      if (!enable) begin
        pass_cnt <= '0;
        verified <= 1'b0;
        if (!STICKY) fault <= 1'b0;
      end else if (lost) begin
        pass_cnt <= '0;
        verified <= 1'b0;
        if (verified) fault <= 1'b1;
      end else if (state == EVAL) begin
        count       <= edge_cnt;
        count_valid <= 1'b1;
        if (in_tol) begin
          pass_cnt <= pass_inc;
          verified <= (pass_inc == PASS_MAX);
          if (!STICKY) fault <= 1'b0;
        end else begin
          pass_cnt <= '0;
          verified <= 1'b0;
          fault    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Randomized self-checking bench for clk_freq_monitor.
// Reference: edge-count estimate from mon_clk period plus pass-streak model.
module tb_clk_freq_monitor;

  localparam int W     = 1024;
  localparam int EXPC  = 256;
  localparam int TOL   = 4;
  localparam int NPASS = 4;
  localparam int CW    = 16;
  localparam int CLK_P = 10000;

`ifdef CLKMON_STICKY_FAULT_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          enable = 1'b0;
  logic          pll_locked = 1'b0;
  logic          mon_clk = 1'b0;
  logic [CW-1:0] count;
  logic          count_valid;
  logic          verified;
  logic          fault;

  int total = 0;
  int bad = 0;
  int mon_half = 20000;
  int m_streak = 0;
  bit m_fault = 1'b0;

  clk_freq_monitor #(
    .WINDOW    (W),
    .EXPECTED  (EXPC),
    .TOLERANCE (TOL),
    .PASSES    (NPASS),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .RSTN        (rstn),
    .enable      (enable),
    .pll_locked  (pll_locked),
    .mon_clk     (mon_clk),
    .count       (count),
    .count_valid (count_valid),
    .verified    (verified),
    .fault       (fault)
  );

  always #(CLK_P / 2) clk = ~clk;

  initial begin
    #($urandom_range(1, 39999));
    forever #(mon_half) mon_clk = ~mon_clk;
  end

  // edges expected in one gate window for the current mon_clk period
  function automatic real exp_count();
    return real'(W) * real'(CLK_P) / (2.0 * real'(mon_half));
  endfunction

  function automatic bit exp_pass();
    real d;
    d = exp_count() - real'(EXPC);
    if (d < 0.0) d = -d;
    return (d + 1.0) <= real'(TOL);
  endfunction

  function automatic bit cnt_ok(input logic [CW-1:0] c);
    real d;
    d = real'(c) - exp_count();
    if (d < 0.0) d = -d;
    return d <= 1.0;
  endfunction

  task automatic model_eval(input bit pass);
    if (pass) begin
      if (m_streak < NPASS) m_streak = m_streak + 1;
      if (!STICKY) m_fault = 1'b0;
    end else begin
      m_streak = 0;
      m_fault  = 1'b1;
    end
  endtask

  task automatic set_period(input bit pass);
    if (pass) mon_half = $urandom_range(19800, 20200);
    else      mon_half = $urandom_range(17000, 18500);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cv(input int budget, output int waited, output bit seen);
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < budget) begin
      @(posedge clk);
      #1;
      waited++;
      seen = count_valid;
    end
  endtask

  task automatic test_reset();
    rstn       = 1'b0;
    enable     = 1'($urandom);
    pll_locked = 1'($urandom);
    step(3);
    total++;
    if (count !== '0) begin
      bad++;
      $display("FAIL reset_count: got %0d want 0", count);
    end
    total++;
    if (count_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_cv: got %b want 0", count_valid);
    end
    total++;
    if (verified !== 1'b0) begin
      bad++;
      $display("FAIL reset_verified: got %b want 0", verified);
    end
    total++;
    if (fault !== 1'b0) begin
      bad++;
      $display("FAIL reset_fault: got %b want 0", fault);
    end
    rstn       = 1'b1;
    enable     = 1'b0;
    pll_locked = 1'b0;
    step(2);
    total++;
    if (verified !== 1'b0 || fault !== 1'b0) begin
      bad++;
      $display("FAIL idle_outputs: got v=%b f=%b want 0 0", verified, fault);
    end
  endtask

  task automatic test_nominal();
    int waited;
    bit seen;
    bit ev;
    set_period(1'b1);
    enable = 1'b1;
    step(2);
    pll_locked = 1'b1;
    for (int w = 0; w < 5; w++) begin
      wait_cv(W + 16, waited, seen);
      total++;
      if (!seen || waited != (w == 0 ? W + 4 : W)) begin
        bad++;
        $display("FAIL nominal_latency w=%0d: got %0d want %0d",
                 w, waited, (w == 0 ? W + 4 : W));
      end
      model_eval(exp_pass());
      total++;
      if (!cnt_ok(count)) begin
        bad++;
        $display("FAIL nominal_count w=%0d: got %0d want %0.2f+-1",
                 w, count, exp_count());
      end
      ev = (m_streak == NPASS);
      total++;
      if (verified !== ev) begin
        bad++;
        $display("FAIL nominal_verified w=%0d: got %b want %b", w, verified, ev);
      end
      total++;
      if (fault !== m_fault) begin
        bad++;
        $display("FAIL nominal_fault w=%0d: got %b want %b", w, fault, m_fault);
      end
      step(1);
      total++;
      if (count_valid !== 1'b0) begin
        bad++;
        $display("FAIL nominal_pulse w=%0d: got %b want 0", w, count_valid);
      end
    end
  endtask

  task automatic test_lock_loss();
    int waited;
    bit seen;
    step($urandom_range(100, 900));
    pll_locked = 1'b0;
    step(2);
    total++;
    if (verified !== 1'b1) begin
      bad++;
      $display("FAIL lock_loss_hold: got %b want 1", verified);
    end
    step(1);
    total++;
    if (verified !== 1'b0) begin
      bad++;
      $display("FAIL lock_loss_verified: got %b want 0", verified);
    end
    total++;
    if (fault !== 1'b1) begin
      bad++;
      $display("FAIL lock_loss_fault: got %b want 1", fault);
    end
    m_streak = 0;
    m_fault  = 1'b1;
    wait_cv(W + 200, waited, seen);
    total++;
    if (seen) begin
      bad++;
      $display("FAIL lock_loss_partial: got count_valid at %0d want none", waited);
    end
    pll_locked = 1'b1;
    wait_cv(W + 16, waited, seen);
    total++;
    if (!seen || waited != W + 4) begin
      bad++;
      $display("FAIL relock_latency: got %0d want %0d", waited, W + 4);
    end
    model_eval(exp_pass());
    total++;
    if (fault !== m_fault) begin
      bad++;
      $display("FAIL relock_fault: got %b want %b", fault, m_fault);
    end
    step(1);
  endtask

  task automatic test_off_freq();
    int waited;
    bit seen;
    enable = 1'b0;
    set_period(1'b0);
    step(1);
    if (!STICKY) m_fault = 1'b0;
    m_streak = 0;
    total++;
    if (fault !== m_fault || verified !== 1'b0) begin
      bad++;
      $display("FAIL disable_outputs: got v=%b f=%b want 0 %b",
               verified, fault, m_fault);
    end
    enable = 1'b1;
    for (int w = 0; w < 2; w++) begin
      wait_cv(W + 16, waited, seen);
      total++;
      if (!seen || waited != (w == 0 ? W + 3 : W)) begin
        bad++;
        $display("FAIL off_latency w=%0d: got %0d want %0d",
                 w, waited, (w == 0 ? W + 3 : W));
      end
      model_eval(exp_pass());
      total++;
      if (!cnt_ok(count)) begin
        bad++;
        $display("FAIL off_count w=%0d: got %0d want %0.2f+-1",
                 w, count, exp_count());
      end
      total++;
      if (fault !== m_fault || verified !== 1'b0) begin
        bad++;
        $display("FAIL off_flags w=%0d: got v=%b f=%b want 0 %b",
                 w, verified, fault, m_fault);
      end
      step(1);
    end
  endtask

  task automatic test_recovery();
    int waited;
    bit seen;
    bit ev;
    pll_locked = 1'b0;
    step(4);
    total++;
    if (fault !== m_fault || verified !== 1'b0) begin
      bad++;
      $display("FAIL unlocked_hold: got v=%b f=%b want 0 %b",
               verified, fault, m_fault);
    end
    set_period(1'b1);
    pll_locked = 1'b1;
    for (int w = 0; w < 2; w++) begin
      wait_cv(W + 16, waited, seen);
      total++;
      if (!seen || waited != (w == 0 ? W + 4 : W)) begin
        bad++;
        $display("FAIL recov_latency w=%0d: got %0d want %0d",
                 w, waited, (w == 0 ? W + 4 : W));
      end
      model_eval(exp_pass());
      total++;
      if (!cnt_ok(count)) begin
        bad++;
        $display("FAIL recov_count w=%0d: got %0d want %0.2f+-1",
                 w, count, exp_count());
      end
      ev = (m_streak == NPASS);
      total++;
      if (fault !== m_fault || verified !== ev) begin
        bad++;
        $display("FAIL recov_flags w=%0d: got v=%b f=%b want %b %b",
                 w, verified, fault, ev, m_fault);
      end
      step(1);
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    bit seen;
    bit ev;
    step($urandom_range(400, 600));
    rstn = 1'b0;
    step(1);
    total++;
    if (count !== '0 || count_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_count: got %0d/%b want 0/0", count, count_valid);
    end
    total++;
    if (verified !== 1'b0 || fault !== 1'b0) begin
      bad++;
      $display("FAIL midrst_flags: got v=%b f=%b want 0 0", verified, fault);
    end
    rstn     = 1'b1;
    m_streak = 0;
    m_fault  = 1'b0;
    for (int w = 0; w < 4; w++) begin
      wait_cv(W + 16, waited, seen);
      total++;
      if (!seen || waited != (w == 0 ? W + 4 : W)) begin
        bad++;
        $display("FAIL midrst_latency w=%0d: got %0d want %0d",
                 w, waited, (w == 0 ? W + 4 : W));
      end
      model_eval(exp_pass());
      total++;
      if (!cnt_ok(count)) begin
        bad++;
        $display("FAIL midrst_count w=%0d: got %0d want %0.2f+-1",
                 w, count, exp_count());
      end
      ev = (m_streak == NPASS);
      total++;
      if (fault !== m_fault || verified !== ev) begin
        bad++;
        $display("FAIL midrst_flags w=%0d: got v=%b f=%b want %b %b",
                 w, verified, fault, ev, m_fault);
      end
      step(1);
    end
  endtask

  task automatic test_enable_lock();
    int waited;
    bit seen;
    step($urandom_range(100, 900));
    enable     = 1'b0;
    pll_locked = 1'b0;
    step(1);
    if (!STICKY) m_fault = 1'b0;
    m_streak = 0;
    total++;
    if (verified !== 1'b0) begin
      bad++;
      $display("FAIL enlock_verified: got %b want 0", verified);
    end
    total++;
    if (fault !== m_fault) begin
      bad++;
      $display("FAIL enlock_fault: got %b want %b", fault, m_fault);
    end
    total++;
    if (!cnt_ok(count)) begin
      bad++;
      $display("FAIL enlock_count_held: got %0d want %0.2f+-1", count, exp_count());
    end
    wait_cv(W + 200, waited, seen);
    total++;
    if (seen) begin
      bad++;
      $display("FAIL enlock_idle_cv: got count_valid at %0d want none", waited);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss();
    test_off_freq();
    test_recovery();
    test_reset_mid();
    test_enable_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
